// File: rtl/instr_loader_if.sv
// rtl/instr_loader_if.sv - byte stream valid/ready bundle feeding the instruction loader
interface instr_loader_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready
    );
endinterface

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - framed byte stream to 16-bit instruction memory writer
module instr_loader #(
    parameter int         ADDR_W    = 4,
    parameter int         DEPTH     = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    instr_loader_if.slave     bs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              hold_cpu,
    output logic              busy,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT,
        S_HI,
        S_LO,
        S_WR,
        S_CHK
    } state_t;

    localparam logic [7:0]        DEPTH_B  = 8'(DEPTH);
    localparam logic [ADDR_W:0]   WC_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        sum_q, sum_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic              hold_cpu_q, hold_cpu_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic [ADDR_W:0]   word_count_inc;
    logic              accept;

    assign bs.byte_ready  = (state_q != S_WR);
    assign busy           = (state_q != S_IDLE);
    assign accept         = bs.byte_valid && bs.byte_ready;
    assign word_count_inc = word_count_q + WC_ONE;

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        hi_d         = hi_q;
        sum_d        = sum_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        hold_cpu_d   = hold_cpu_q;
        load_done_d  = 1'b0;
        load_err_d   = load_err_q;
        word_count_d = word_count_q;

        case (state_q)
            S_IDLE: begin
                if (accept && bs.byte_data == SYNC_BYTE) begin
                    state_d      = S_CNT;
                    load_err_d   = 1'b0;
                    word_count_d = '0;
                    sum_d        = '0;
                    hold_cpu_d   = 1'b1;
                end
            end
            S_CNT: begin
                if (accept) begin
                    if (bs.byte_data == 8'd0 || bs.byte_data > DEPTH_B) begin
                        state_d    = S_IDLE;
                        load_err_d = 1'b1;
                        hold_cpu_d = 1'b0;
                    end else begin
                        n_d        = bs.byte_data[ADDR_W:0];
                        mem_addr_d = '0;
                        state_d    = S_HI;
                    end
                end
            end
            S_HI: begin
                if (accept) begin
                    hi_d    = bs.byte_data;
                    sum_d   = sum_q + bs.byte_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    mem_wdata_d = {hi_q, bs.byte_data};
                    sum_d       = sum_q + bs.byte_data;
                    mem_we_d    = 1'b1;
                    state_d     = S_WR;
                end
            end
            S_WR: begin
                word_count_d = word_count_inc;
                // The last word keeps its address so mem_addr stays within 0..N-1.
                if (word_count_inc == n_q) begin
                    state_d = S_CHK;
                end else begin
                    mem_addr_d = mem_addr_q + ADDR_ONE;
                    state_d    = S_HI;
                end
            end
            S_CHK: begin
                if (accept) begin
                    if (bs.byte_data == sum_q) begin
                        load_done_d = 1'b1;
                    end else begin
                        load_err_d = 1'b1;
                    end
                    hold_cpu_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d    = S_IDLE;
                hold_cpu_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            hi_q         <= '0;
            sum_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            hold_cpu_q   <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            hi_q         <= hi_d;
            sum_q        <= sum_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            hold_cpu_q   <= hold_cpu_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
            word_count_q <= word_count_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign hold_cpu   = hold_cpu_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - randomized and directed bench for instr_loader against a frame parser model
module tb_instr_loader;
    localparam logic [7:0] SYNC  = 8'hA5;
    localparam int         DEPTH = 16;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        hold_cpu;
    logic        busy;
    logic        load_done;
    logic        load_err;
    logic [4:0]  word_count;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int done_cyc = 0;

    logic [19:0] exp_wr[$];
    bit          exp_res[$];
    logic        m_err = 1'b0;
    int          m_wc  = 0;
    logic        err_prev = 1'b0;
    logic [19:0] e;
    bit          r;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_loader_if bs();

    instr_loader #(.ADDR_W(4), .DEPTH(DEPTH), .SYNC_BYTE(SYNC)) dut (
        .clk        (clk),
        .rst        (rst),
        .bs         (bs),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .hold_cpu   (hold_cpu),
        .busy       (busy),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    // Frame parser: turns a whole byte stream into expected writes and outcomes.
    task automatic model_stream(input bq_t s);
        int i = 0;
        int n;
        int avail;
        logic [7:0] sum;
        logic [3:0] wa;
        while (i < s.size()) begin
            if (s[i] != SYNC) begin
                i++;
                continue;
            end
            m_err = 1'b0;
            m_wc  = 0;
            if (i + 1 >= s.size()) break;
            n = int'(s[i+1]);
            if (n == 0 || n > DEPTH) begin
                m_err = 1'b1;
                exp_res.push_back(1'b0);
                i += 2;
                continue;
            end
            sum   = 8'd0;
            avail = (s.size() - i - 2) / 2;
            if (avail > n) avail = n;
            for (int w = 0; w < avail; w++) begin
                wa = w[3:0];
                exp_wr.push_back({wa, s[i+2+2*w], s[i+3+2*w]});
                sum += s[i+2+2*w];
                sum += s[i+3+2*w];
                m_wc++;
            end
            if (i + 2 + 2*n >= s.size()) break;
            if (s[i+2+2*n] == sum) exp_res.push_back(1'b1);
            else begin
                exp_res.push_back(1'b0);
                m_err = 1'b1;
            end
            i += 3 + 2*n;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard = 0;
        for (int g = 0; g < gap; g++) begin
            bs.byte_valid = 1'b0;
            @(negedge clk);
        end
        bs.byte_valid = 1'b1;
        bs.byte_data  = b;
        while (!bs.byte_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!bs.byte_ready) chk("ready_timeout", {31'd0, bs.byte_ready}, 1);
        @(negedge clk);
    endtask

    task automatic drive_stream(input bq_t s, input int mingap, input int maxgap);
        for (int i = 0; i < s.size(); i++)
            send_byte(s[i], $urandom_range(maxgap, mingap));
        bs.byte_valid = 1'b0;
    endtask

    task automatic finish_frame(input string tag);
        int guard = 0;
        bs.byte_valid = 1'b0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        chk({tag, "_idle"},     {31'd0, busy}, 0);
        chk({tag, "_wr_left"},  exp_wr.size(), 0);
        chk({tag, "_res_left"}, exp_res.size(), 0);
        chk({tag, "_err"},      {31'd0, load_err}, {31'd0, m_err});
        chk({tag, "_wc"},       {27'd0, word_count}, m_wc);
        chk({tag, "_hold"},     {31'd0, hold_cpu}, 0);
        exp_wr.delete();
        exp_res.delete();
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            chk("wr_ready_low", {31'd0, bs.byte_ready}, 0);
            chk("wr_hold", {31'd0, hold_cpu}, 1);
            if (exp_wr.size() == 0) chk("wr_extra", {31'd0, mem_we}, 0);
            else begin
                e = exp_wr.pop_front();
                chk("wr_addr", {28'd0, mem_addr}, {28'd0, e[19:16]});
                chk("wr_data", {16'd0, mem_wdata}, {16'd0, e[15:0]});
            end
        end
        if (load_done) begin
            done_cyc = cyc;
            chk("done_hold", {31'd0, hold_cpu}, 0);
            chk("done_noerr", {31'd0, load_err}, 0);
            if (exp_res.size() == 0) chk("done_extra", {31'd0, load_done}, 0);
            else begin
                r = exp_res.pop_front();
                chk("res_kind", {31'd0, load_done}, {31'd0, r});
            end
        end
        if (load_err && !err_prev) begin
            chk("err_hold", {31'd0, hold_cpu}, 0);
            if (exp_res.size() == 0) chk("err_extra", {31'd0, load_err}, 0);
            else begin
                r = exp_res.pop_front();
                chk("res_kind", {31'd0, load_done}, {31'd0, r});
            end
        end
        err_prev = load_err;
    end

    initial begin
        bq_t s;
        int  start;
        int  n;
        int  kind;
        int  mg;
        logic [7:0] b;
        logic [7:0] sum;

        bs.byte_valid = 1'b0;
        bs.byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_we",    {31'd0, mem_we}, 0);
        chk("rst_addr",  {28'd0, mem_addr}, 0);
        chk("rst_wdata", {16'd0, mem_wdata}, 0);
        chk("rst_hold",  {31'd0, hold_cpu}, 0);
        chk("rst_busy",  {31'd0, busy}, 0);
        chk("rst_flags", {30'd0, load_done, load_err}, 0);
        chk("rst_wc",    {27'd0, word_count}, 0);
        chk("rst_ready", {31'd0, bs.byte_ready}, 1);
        rst = 1'b1;
        @(negedge clk);

        // Good 3-word frame, valid held high, with frame latency.
        s = '{8'hA5, 8'h03, 8'h12, 8'h98, 8'h22, 8'h98, 8'h32, 8'hF0, 8'h86};
        model_stream(s);
        start = cyc;
        drive_stream(s, 0, 0);
        finish_frame("good3");
        chk("frame_cycles", done_cyc - start, 3*3 + 3);

        // Bad checksum, then a new SYNC clears the sticky error.
        s = '{8'hA5, 8'h03, 8'h12, 8'h98, 8'h22, 8'h98, 8'h32, 8'hF0, 8'h87};
        model_stream(s);
        drive_stream(s, 0, 0);
        finish_frame("badchk");
        s = '{8'hA5, 8'h01, 8'h7E, 8'h01, 8'h7F};
        model_stream(s);
        send_byte(8'hA5, 0);
        chk("sync_clears_err", {31'd0, load_err}, 0);
        s.pop_front();
        drive_stream(s, 0, 0);
        finish_frame("after_err");

        // Leading junk ignored, then a 1-word zero frame.
        s = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h00, 8'h00};
        model_stream(s);
        drive_stream('{8'h00, 8'hFF, 8'h5A}, 0, 0);
        chk("junk_busy", {31'd0, busy}, 0);
        drive_stream('{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00}, 0, 0);
        finish_frame("junk");

        s = '{8'hA5, 8'h00};
        model_stream(s);
        drive_stream(s, 0, 0);
        finish_frame("n0");
        s = '{8'hA5, 8'h11};
        model_stream(s);
        drive_stream(s, 0, 0);
        finish_frame("n17");

        // Toggling valid across a 2-word frame.
        s = '{8'hA5, 8'h02, 8'hC3, 8'h3C, 8'hA5, 8'h5A, 8'hFE};
        model_stream(s);
        drive_stream(s, 1, 1);
        finish_frame("toggle");

        // Mid-frame reset after the third data byte.
        s = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33};
        model_stream(s);
        drive_stream(s, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mrst_busy", {31'd0, busy}, 0);
        chk("mrst_hold", {31'd0, hold_cpu}, 0);
        chk("mrst_addr", {28'd0, mem_addr}, 0);
        chk("mrst_we",   {31'd0, mem_we}, 0);
        chk("mrst_wc",   {27'd0, word_count}, 0);
        m_err = 1'b0;
        m_wc  = 0;
        repeat (5) @(negedge clk);
        chk("mrst_wr_left", exp_wr.size(), 0);
        s = '{8'hA5, 8'h02, 8'h44, 8'h55, 8'h66, 8'h77, 8'h98};
        model_stream(s);
        drive_stream(s, 0, 0);
        finish_frame("post_rst");

        // Randomized frames: good, bad checksum, bad count, leading junk, gaps.
        for (int f = 0; f < 40; f++) begin
            s = {};
            repeat ($urandom_range(2, 0)) begin
                b = 8'($urandom);
                if (b == SYNC) b = 8'h00;
                s.push_back(b);
            end
            s.push_back(SYNC);
            kind = $urandom_range(9, 0);
            if (kind == 0) begin
                b = ($urandom_range(1, 0) == 1) ? 8'h00 : 8'($urandom_range(255, 17));
                s.push_back(b);
            end else begin
                n = (f % 8 == 0) ? DEPTH : $urandom_range(DEPTH, 1);
                s.push_back(8'(n));
                sum = 8'd0;
                for (int k = 0; k < 2*n; k++) begin
                    b = ($urandom_range(7, 0) == 0) ? SYNC : 8'($urandom);
                    s.push_back(b);
                    sum += b;
                end
                if (kind == 1) sum += 8'($urandom_range(255, 1));
                s.push_back(sum);
            end
            mg = $urandom_range(3, 0);
            model_stream(s);
            drive_stream(s, 0, mg);
            finish_frame("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
